branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 10: PC/target width, word-addressed.
REQ-002 SHALL have parameter SET_BITS, default 4: number of sets is 2^SET_BITS, indexed by pc[SET_BITS-1:0].
REQ-003 SHALL have parameter WAYS, default 4: ways per set, a power of 2 and at least 2.
REQ-004 SHALL have parameter CTR_W, default 2: saturating counter width, at least 2.
REQ-005 SHALL have parameter REPL, default 0: 0 = per-set FIFO; 1 = invalid-first, then weakest-counter.
REQ-006 SHALL have one clock and a synchronous, active-high reset:
  CLK  in  1  clock, all state on the rising edge
  rst  in  1  synchronous active-high reset
REQ-007 SHALL have these ports:
  en  in  1  global stall-qualified enable
  isr_en  in  1  context bit, part of the tag
  if_pc  in  PC_W  fetch PC
  if_hit  out  1  fetch lookup hit
  if_prediction  out  1  predicted taken
  if_pbt  out  PC_W  predicted target
  id_pc  in  PC_W  decode PC
  id_target  in  PC_W  decoded target
  id_is_btype  in  1  decode holds a conditional branch
  id_is_jump  in  1  decode holds a jump
  id_jump_in_btb  out  1  decode jump already present in the table
  exe_pc  in  PC_W  execute PC
  exe_valid  in  1  a resolved conditional branch is in execute
  exe_taken  in  1  resolved outcome
  exe_target  in  PC_W  computed branch target
  exe_correction  out  2  00 none, 10 select CNI, 11 select PBT
  exe_pbt  out  PC_W  correct taken target
  exe_cni  out  PC_W  fall-through PC
  branch_flush  out  1  pipeline flush

Function
REQ-008 Entry SHALL be {valid, tag, target[PC_W], ctr[CTR_W]}, where tag = {isr_en, pc[PC_W-1:SET_BITS]}.
REQ-009 Lookup (IF, ID, EXE) SHALL be combinational: hit = any valid way with an equal tag; the lowest matching way index is selected.
REQ-010 if_hit is the fetch hit; if_prediction = hit & ctr[CTR_W-1]; if_pbt = hit ? target : 0.
REQ-011 id_jump_in_btb SHALL be id_is_jump & ID hit.
REQ-012 Insert SHALL occur when en & (id_is_btype | id_is_jump) & ID miss; the entry is written valid with id_target and ctr = all-ones for a jump, else 2^(CTR_W-1)-1 (weakly not-taken).
REQ-013 Victim selection:
  - REPL=0: the way at the set's FIFO pointer; the pointer increments mod WAYS on every insert into that set.
  - REPL=1: the lowest-index invalid way; else the lowest ctr, ties to lowest index; the pointer is unused.
REQ-014 Counter update SHALL occur when en & exe_valid & EXE hit: +1 if exe_taken, -1 otherwise, saturating at all-ones and 0; there is no write when already saturated.
REQ-015 An EXE miss SHALL update nothing; its prediction is treated as not-taken.
REQ-016 When an insert and an update happen in the same cycle:
  - different set or way: both SHALL occur;
  - same set and way: the insert wins and the update is dropped.
REQ-017 Prediction and mispredict:
  - pred = EXE hit & ctr[CTR_W-1];
  - mispredict = exe_valid & (pred != exe_taken);
  - exe_correction = mispredict ? {1, exe_taken} : 00.
REQ-018 exe_pbt = EXE hit ? stored target : exe_target; exe_cni = exe_pc + 1, modulo 2^PC_W.
REQ-019 branch_flush SHALL be combinational from flush_q:
  - flush_q = 1: flush = 1, next = 0;
  - else mispredict: flush = 1, next = 1;
  - else: flush = 0, next = id_is_jump & ID miss.
  flush_q loads next only when en.
REQ-020 With en = 0, the table, pointers and flush_q SHALL hold; outputs stay combinational.
REQ-021 Update and insert latency SHALL be one cycle: the write is visible to lookups in the cycle after the edge.

Reset
REQ-022 rst SHALL clear every valid bit, ctr, target and FIFO pointer, and flush_q, regardless of en.
REQ-023 After reset with idle inputs, if_hit, if_prediction, if_pbt, id_jump_in_btb, exe_correction and branch_flush SHALL all be 0.
REQ-024 rst asserted mid-operation SHALL discard any insert, update or pending flush in that cycle.

Verification
REQ-025 Defaults throughout. Reset, then if_pc=0x123 -> if_hit=0, if_prediction=0, if_pbt=0, branch_flush=0.
REQ-026 Train a branch:
  - Insert branch id_pc=0x045, id_target=0x080 -> next cycle if_pc=0x045 gives if_hit=1, if_prediction=0.
  - Then exe_valid=1, exe_taken=1 at 0x045 -> exe_correction=11, exe_pbt=0x080, branch_flush=1 for 2 cycles.
  - Then if_prediction=1.
REQ-027 FIFO eviction: insert 0x005, 0x015, 0x025, 0x035, 0x045 -> 0x005 misses, the other four hit; a not-taken update at a hit with ctr=0 leaves ctr at 0.
REQ-028 REPL=1 eviction: fill set 5, train 0x025 to ctr=3 and the others to 2 except 0x035 at 1, then insert 0x045 -> 0x035 evicted, all others hit.
REQ-029 Context and jumps:
  - Insert 0x045 with isr_en=0, look up with isr_en=1 -> miss.
  - ID jump miss at 0x060 -> branch_flush=1 next cycle only.
  - Repeat the jump -> id_jump_in_btb=1, no flush.
REQ-030 Same-cycle insert 0x016 (set 6) and update at 0x045 (set 5) -> both visible next cycle; with en=0 the table is unchanged.

Source files
------------

// File: rtl/branch_target_buffer.sv
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Set-associative branch target buffer. Combinational lookups
//                on the IF, ID and EXE ports, insertion on decode-side misses,
//                saturating-counter training from execute, and flush control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer #(
    parameter int PC_W     = 10,
    parameter int SET_BITS = 4,
    parameter int WAYS     = 4,
    parameter int CTR_W    = 2,
    parameter int REPL     = 0
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            en,
    input  logic            isr_en,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_hit,
    output logic            if_prediction,
    output logic [PC_W-1:0] if_pbt,
    input  logic [PC_W-1:0] id_pc,
    input  logic [PC_W-1:0] id_target,
    input  logic            id_is_btype,
    input  logic            id_is_jump,
    output logic            id_jump_in_btb,
    input  logic [PC_W-1:0] exe_pc,
    input  logic            exe_valid,
    input  logic            exe_taken,
    input  logic [PC_W-1:0] exe_target,
    output logic [1:0]      exe_correction,
    output logic [PC_W-1:0] exe_pbt,
    output logic [PC_W-1:0] exe_cni,
    output logic            branch_flush
);

    localparam int SETS     = 1 << SET_BITS;
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int TAG_W    = PC_W - SET_BITS + 1;
    localparam int N_PORTS  = 3;
    localparam int C_IF     = 0;
    localparam int C_ID     = 1;
    localparam int C_EXE    = 2;

    localparam logic [CTR_W-1:0] C_CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] C_CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

    logic [WAYS-1:0]     r_valid    [SETS];
    logic [TAG_W-1:0]    r_tag      [SETS][WAYS];
    logic [PC_W-1:0]     r_target   [SETS][WAYS];
    logic [CTR_W-1:0]    r_ctr      [SETS][WAYS];
    logic [WAY_BITS-1:0] r_fifo_ptr [SETS];
    logic                r_flush_q;

    logic [PC_W-1:0]     w_lk_pc  [N_PORTS];
    logic [SET_BITS-1:0] w_lk_set [N_PORTS];
    logic [N_PORTS-1:0]  w_lk_hit;
    logic [WAY_BITS-1:0] w_lk_way [N_PORTS];
    logic [CTR_W-1:0]    w_lk_ctr [N_PORTS];
    logic [PC_W-1:0]     w_lk_tgt [N_PORTS];

    logic [WAY_BITS-1:0] w_victim;
    logic                w_ins;
    logic                w_upd;
    logic                w_ctr_sat;
    logic [CTR_W-1:0]    w_ctr_next;
    logic [CTR_W-1:0]    w_ins_ctr;
    logic                w_pred_exe;
    logic                w_mispredict;
    logic                w_flush_next;

    assign w_lk_pc[C_IF]  = if_pc;
    assign w_lk_pc[C_ID]  = id_pc;
    assign w_lk_pc[C_EXE] = exe_pc;

    // Descending scan so the lowest matching way is the one left selected
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_lk_set[p] = w_lk_pc[p][SET_BITS-1:0];
            w_lk_hit[p] = 1'b0;
            w_lk_way[p] = '0;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (r_valid[w_lk_pc[p][SET_BITS-1:0]][w] &&
                    r_tag[w_lk_pc[p][SET_BITS-1:0]][w] == {isr_en, w_lk_pc[p][PC_W-1:SET_BITS]}) begin
                    w_lk_hit[p] = 1'b1;
                    w_lk_way[p] = WAY_BITS'(w);
                end
            end
            w_lk_ctr[p] = r_ctr[w_lk_pc[p][SET_BITS-1:0]][w_lk_way[p]];
            w_lk_tgt[p] = r_target[w_lk_pc[p][SET_BITS-1:0]][w_lk_way[p]];
        end
    end

    generate
        if (REPL == 0) begin : g_fifo
            assign w_victim = r_fifo_ptr[w_lk_set[C_ID]];
        end else begin : g_weakest
            logic [CTR_W-1:0] w_min_ctr;
            // Weakest counter first, then any invalid way overrides it
            always_comb begin
                w_victim  = '0;
                w_min_ctr = r_ctr[w_lk_set[C_ID]][0];
                for (int w = 1; w < WAYS; w++) begin
                    if (r_ctr[w_lk_set[C_ID]][w] < w_min_ctr) begin
                        w_min_ctr = r_ctr[w_lk_set[C_ID]][w];
                        w_victim  = WAY_BITS'(w);
                    end
                end
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!r_valid[w_lk_set[C_ID]][w]) begin
                        w_victim = WAY_BITS'(w);
                    end
                end
            end
        end
    endgenerate

    assign w_ins      = en & (id_is_btype | id_is_jump) & ~w_lk_hit[C_ID];
    assign w_ins_ctr  = id_is_jump ? C_CTR_MAX : C_CTR_WEAK_NT;
    assign w_ctr_sat  = exe_taken ? (w_lk_ctr[C_EXE] == C_CTR_MAX) : (w_lk_ctr[C_EXE] == '0);
    assign w_ctr_next = exe_taken ? w_lk_ctr[C_EXE] + CTR_W'(1) : w_lk_ctr[C_EXE] - CTR_W'(1);
    // An insert overwriting the very entry being trained takes priority
    assign w_upd      = en & exe_valid & w_lk_hit[C_EXE] & ~w_ctr_sat &
                        ~(w_ins && w_lk_set[C_ID] == w_lk_set[C_EXE] && w_victim == w_lk_way[C_EXE]);

    assign w_pred_exe     = w_lk_hit[C_EXE] & w_lk_ctr[C_EXE][CTR_W-1];
    assign w_mispredict   = exe_valid & (w_pred_exe != exe_taken);
    assign exe_correction = w_mispredict ? {1'b1, exe_taken} : 2'b00;
    assign exe_pbt        = w_lk_hit[C_EXE] ? w_lk_tgt[C_EXE] : exe_target;
    assign exe_cni        = exe_pc + PC_W'(1);

    assign if_hit         = w_lk_hit[C_IF];
    assign if_prediction  = w_lk_hit[C_IF] & w_lk_ctr[C_IF][CTR_W-1];
    assign if_pbt         = w_lk_hit[C_IF] ? w_lk_tgt[C_IF] : '0;
    assign id_jump_in_btb = id_is_jump & w_lk_hit[C_ID];

    // Flush lasts two cycles on a mispredict, one cycle on an unknown jump
    assign branch_flush = r_flush_q | w_mispredict;
    assign w_flush_next = r_flush_q    ? 1'b0 :
                          w_mispredict ? 1'b1 :
                          (id_is_jump & ~w_lk_hit[C_ID]);

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s]    <= '0;
                r_fifo_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_ctr[s][w]    <= '0;
                end
            end
            r_flush_q <= 1'b0;
        end else if (en) begin
            if (w_upd) begin
                r_ctr[w_lk_set[C_EXE]][w_lk_way[C_EXE]] <= w_ctr_next;
            end
            if (w_ins) begin
                r_valid[w_lk_set[C_ID]][w_victim]  <= 1'b1;
                r_tag[w_lk_set[C_ID]][w_victim]    <= {isr_en, id_pc[PC_W-1:SET_BITS]};
                r_target[w_lk_set[C_ID]][w_victim] <= id_target;
                r_ctr[w_lk_set[C_ID]][w_victim]    <= w_ins_ctr;
                r_fifo_ptr[w_lk_set[C_ID]]         <= r_fifo_ptr[w_lk_set[C_ID]] + WAY_BITS'(1);
            end
            r_flush_q <= w_flush_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ============================================================================
//  Module      : tb_branch_target_buffer
//  Description : Drives a FIFO-replacement and a weakest-replacement instance
//                in lockstep against an entry-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_buffer;

    localparam int SETS = 16;
    localparam int WAYS = 4;

    typedef struct {
        bit v;
        bit isr;
        int hi;
        int tgt;
        int ctr;
    } ent_t;

    logic       CLK = 1'b0;
    logic       rst, en, isr_en, id_is_btype, id_is_jump, exe_valid, exe_taken;
    logic [9:0] if_pc, id_pc, id_target, exe_pc, exe_target;

    logic       d_if_hit [2];
    logic       d_if_pred[2];
    logic       d_jib    [2];
    logic       d_flush  [2];
    logic [9:0] d_if_pbt [2];
    logic [9:0] d_exe_pbt[2];
    logic [9:0] d_exe_cni[2];
    logic [1:0] d_corr   [2];

    ent_t mdl [2][SETS][WAYS];
    int   fptr[2][SETS];
    bit   fq  [2];

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    generate
        for (genvar r = 0; r < 2; r++) begin : g_dut
            branch_target_buffer #(.REPL(r)) u_dut (
                .CLK           (CLK),
                .rst           (rst),
                .en            (en),
                .isr_en        (isr_en),
                .if_pc         (if_pc),
                .if_hit        (d_if_hit[r]),
                .if_prediction (d_if_pred[r]),
                .if_pbt        (d_if_pbt[r]),
                .id_pc         (id_pc),
                .id_target     (id_target),
                .id_is_btype   (id_is_btype),
                .id_is_jump    (id_is_jump),
                .id_jump_in_btb(d_jib[r]),
                .exe_pc        (exe_pc),
                .exe_valid     (exe_valid),
                .exe_taken     (exe_taken),
                .exe_target    (exe_target),
                .exe_correction(d_corr[r]),
                .exe_pbt       (d_exe_pbt[r]),
                .exe_cni       (d_exe_cni[r]),
                .branch_flush  (d_flush[r])
            );
        end
    endgenerate

    task automatic ck(input string tag, input int r, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, r, obs, exp);
        end
    endtask

    function automatic int find(int r, logic [9:0] pc);
        for (int w = 0; w < WAYS; w++)
            if (mdl[r][int'(pc) % SETS][w].v && mdl[r][int'(pc) % SETS][w].isr == isr_en &&
                mdl[r][int'(pc) % SETS][w].hi == int'(pc) / SETS)
                return w;
        return -1;
    endfunction

    function automatic bit look(int r, logic [9:0] pc, output ent_t e);
        int w;
        w = find(r, pc);
        e = '{default: 0};
        if (w >= 0) e = mdl[r][int'(pc) % SETS][w];
        return w >= 0;
    endfunction

    function automatic int victim(int r, int s);
        int best;
        if (r == 0) return fptr[r][s];
        for (int w = 0; w < WAYS; w++)
            if (!mdl[r][s][w].v) return w;
        best = 0;
        for (int w = 1; w < WAYS; w++)
            if (mdl[r][s][w].ctr < mdl[r][s][best].ctr) best = w;
        return best;
    endfunction

    task automatic model_check();
        for (int r = 0; r < 2; r++) begin
            ent_t fe, de, ee;
            bit   fh, dh, eh, pred, misp;
            fh   = look(r, if_pc, fe);
            dh   = look(r, id_pc, de);
            eh   = look(r, exe_pc, ee);
            pred = eh && ee.ctr >= 2;
            misp = exe_valid && (pred != exe_taken);
            ck("if_hit",  r, d_if_hit[r],  fh);
            ck("if_pred", r, d_if_pred[r], fh && fe.ctr >= 2);
            ck("if_pbt",  r, d_if_pbt[r],  fh ? fe.tgt : 0);
            ck("jump_in_btb", r, d_jib[r], id_is_jump && dh);
            ck("exe_corr", r, d_corr[r], misp ? {1'b1, exe_taken} : 2'b00);
            ck("exe_pbt", r, d_exe_pbt[r], eh ? ee.tgt : int'(exe_target));
            ck("exe_cni", r, d_exe_cni[r], (int'(exe_pc) + 1) % 1024);
            ck("flush",   r, d_flush[r],   fq[r] || misp);
        end
    endtask

    task automatic model_update();
        for (int r = 0; r < 2; r++) begin
            int iw, ew, si, se, vw;
            bit pred, misp;
            if (rst) begin
                for (int s = 0; s < SETS; s++) begin
                    fptr[r][s] = 0;
                    for (int w = 0; w < WAYS; w++) mdl[r][s][w] = '{default: 0};
                end
                fq[r] = 0;
            end else if (en) begin
                iw   = find(r, id_pc);
                ew   = find(r, exe_pc);
                si   = int'(id_pc) % SETS;
                se   = int'(exe_pc) % SETS;
                pred = ew >= 0 && mdl[r][se][ew].ctr >= 2;
                misp = exe_valid && (pred != exe_taken);
                vw   = victim(r, si);
                if (exe_valid && ew >= 0) begin
                    if (exe_taken) mdl[r][se][ew].ctr = (mdl[r][se][ew].ctr == 3) ? 3 : mdl[r][se][ew].ctr + 1;
                    else           mdl[r][se][ew].ctr = (mdl[r][se][ew].ctr == 0) ? 0 : mdl[r][se][ew].ctr - 1;
                end
                if ((id_is_btype || id_is_jump) && iw < 0) begin
                    mdl[r][si][vw] = '{v: 1'b1, isr: isr_en, hi: int'(id_pc) / SETS,
                                       tgt: int'(id_target), ctr: id_is_jump ? 3 : 1};
                    fptr[r][si] = (fptr[r][si] + 1) % WAYS;
                end
                fq[r] = fq[r] ? 1'b0 : (misp ? 1'b1 : (id_is_jump && iw < 0));
            end
        end
    endtask

    task automatic sample();
        @(negedge CLK);
        model_check();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic ins(input logic [9:0] pc, input logic [9:0] tgt, input bit jump);
        id_pc = pc; id_target = tgt; id_is_btype = !jump; id_is_jump = jump;
        cyc();
        id_is_btype = 1'b0; id_is_jump = 1'b0;
    endtask

    task automatic upd(input logic [9:0] pc, input bit taken);
        exe_pc = pc; exe_valid = 1'b1; exe_taken = taken; exe_target = 10'h3FF;
        cyc();
        exe_valid = 1'b0;
    endtask

    task automatic probe_hit(input int r, input logic [9:0] pc, input bit exp);
        if_pc = pc;
        sample();
        ck("probe_hit", r, d_if_hit[r], exp);
        advance();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; isr_en = 1'b0;
        if_pc = '0; id_pc = '0; id_target = '0; id_is_btype = 1'b0; id_is_jump = 1'b0;
        exe_pc = '0; exe_valid = 1'b0; exe_taken = 1'b0; exe_target = '0;
        cyc();
        rst = 1'b0;

        // Idle after reset
        if_pc = 10'h123;
        sample();
        for (int r = 0; r < 2; r++) begin
            ck("rst_if_hit", r, d_if_hit[r], 0);
            ck("rst_if_pred", r, d_if_pred[r], 0);
            ck("rst_if_pbt", r, d_if_pbt[r], 0);
            ck("rst_flush", r, d_flush[r], 0);
            ck("rst_corr", r, d_corr[r], 0);
        end
        advance();

        // Train a branch
        ins(10'h045, 10'h080, 1'b0);
        if_pc = 10'h045;
        sample();
        ck("train_hit", 0, d_if_hit[0], 1);
        ck("train_pred0", 0, d_if_pred[0], 0);
        advance();
        exe_pc = 10'h045; exe_valid = 1'b1; exe_taken = 1'b1; exe_target = 10'h200;
        sample();
        ck("train_corr", 0, d_corr[0], 2'b11);
        ck("train_pbt", 0, d_exe_pbt[0], 10'h080);
        ck("train_flush1", 0, d_flush[0], 1);
        advance();
        exe_valid = 1'b0;
        sample();
        ck("train_flush2", 0, d_flush[0], 1);
        advance();
        sample();
        ck("train_flush3", 0, d_flush[0], 0);
        ck("train_pred1", 0, d_if_pred[0], 1);
        advance();

        // FIFO eviction and saturation at zero
        do_reset();
        for (int i = 0; i < 5; i++) ins(10'(16 * i + 5), 10'(10'h100 + i), 1'b0);
        for (int i = 0; i < 5; i++) probe_hit(0, 10'(16 * i + 5), i != 0);
        upd(10'h015, 1'b0);
        upd(10'h015, 1'b0);
        upd(10'h015, 1'b1);
        if_pc = 10'h015;
        sample();
        ck("sat0_pred", 0, d_if_pred[0], 0);
        advance();

        // Weakest-counter eviction
        do_reset();
        for (int i = 0; i < 4; i++) ins(10'(16 * i + 5), 10'(10'h140 + i), 1'b0);
        upd(10'h025, 1'b1); upd(10'h025, 1'b1);
        upd(10'h005, 1'b1); upd(10'h015, 1'b1);
        ins(10'h045, 10'h1C0, 1'b0);
        for (int i = 0; i < 5; i++) probe_hit(1, 10'(16 * i + 5), i != 3);

        // Context bit and jumps
        do_reset();
        ins(10'h045, 10'h080, 1'b0);
        isr_en = 1'b1;
        probe_hit(0, 10'h045, 1'b0);
        probe_hit(1, 10'h045, 1'b0);
        isr_en = 1'b0;
        id_pc = 10'h060; id_target = 10'h010; id_is_jump = 1'b1;
        sample();
        ck("jump_flush_now", 0, d_flush[0], 0);
        advance();
        id_is_jump = 1'b0;
        sample();
        ck("jump_flush_next", 0, d_flush[0], 1);
        advance();
        sample();
        ck("jump_flush_end", 0, d_flush[0], 0);
        advance();
        id_is_jump = 1'b1;
        sample();
        ck("jump_in_btb", 0, d_jib[0], 1);
        advance();
        id_is_jump = 1'b0;
        sample();
        ck("jump_no_flush", 0, d_flush[0], 0);
        advance();

        // Simultaneous insert and update in different sets, then hold with en=0
        id_pc = 10'h016; id_target = 10'h0AA; id_is_btype = 1'b1;
        exe_pc = 10'h045; exe_valid = 1'b1; exe_taken = 1'b1;
        cyc();
        id_is_btype = 1'b0; exe_valid = 1'b0;
        probe_hit(0, 10'h016, 1'b1);
        if_pc = 10'h045;
        sample();
        ck("dual_pred", 0, d_if_pred[0], 1);
        advance();
        en = 1'b0;
        id_pc = 10'h027; id_is_btype = 1'b1;
        exe_pc = 10'h045; exe_valid = 1'b1; exe_taken = 1'b0;
        cyc(); cyc();
        en = 1'b1; id_is_btype = 1'b0; exe_valid = 1'b0;
        probe_hit(0, 10'h027, 1'b0);
        if_pc = 10'h045;
        sample();
        ck("hold_pred", 0, d_if_pred[0], 1);
        advance();

        // Randomized traffic on a small PC pool
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            en          = ($urandom_range(0, 4) != 0);
            isr_en      = ($urandom_range(0, 7) == 0);
            if_pc       = 10'($urandom_range(0, 3) * 16 + $urandom_range(0, 3));
            id_pc       = 10'($urandom_range(0, 7) * 16 + $urandom_range(0, 3));
            exe_pc      = 10'($urandom_range(0, 7) * 16 + $urandom_range(0, 3));
            id_target   = 10'($urandom);
            exe_target  = 10'($urandom);
            id_is_btype = ($urandom_range(0, 2) == 0);
            id_is_jump  = !id_is_btype && ($urandom_range(0, 4) == 0);
            exe_valid   = ($urandom_range(0, 1) == 0);
            exe_taken   = ($urandom_range(0, 1) == 0);
            if (i % 100 == 99) exe_pc = 10'h3FF;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
